// File: rtl/mem_a_pkg.sv
// Shared types and sizing helpers for the operand-A skew buffer.
package mem_a_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } skew_state_t;

  // Number of enabled edges needed to stream a whole tile with diagonal skew.
  function automatic int stream_len(input int dim);
    return (2 * dim) - 1;
  endfunction

  // Counter width able to hold every stream step plus the out-of-range marker.
  function automatic int cnt_bits(input int dim);
    return $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/mem_a_row.sv
// One row of the staged A tile: full-row write, combinational column read.
module mem_a_row
  import mem_a_pkg::*;
#(
  parameter int BITS_AB  = 8,
  parameter int DIM      = 8,
  parameter int IDX_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [DIM*BITS_AB-1:0] wdata_i,
  input  logic [IDX_BITS-1:0]    ridx_i,
  output logic [BITS_AB-1:0]     rdata_o
);

  logic [DIM-1:0][BITS_AB-1:0] mem_q;
  logic [BITS_AB-1:0]          rdata_s;

  // Row storage: cleared by reset, whole row replaced on a write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      for (int c = 0; c < DIM; c++) begin
        mem_q[c] <= wdata_i[c*BITS_AB +: BITS_AB];
      end
    end else begin
      mem_q <= mem_q;
    end
  end

  // Column select; any index outside 0..DIM-1 matches nothing and reads 0.
  always_comb begin
    rdata_s = '0;
    for (int c = 0; c < DIM; c++) begin
      rdata_s = rdata_s | ((ridx_i == IDX_BITS'(c)) ? mem_q[c] : {BITS_AB{1'b0}});
    end
  end

  assign rdata_o = rdata_s;

endmodule

// File: rtl/mem_a_skew.sv
// Operand-A staging buffer feeding the left edge of the systolic array.
// Loads a DIM x DIM tile one row per cycle, then streams it column by
// column with row r delayed r cycles so it lines up with the B/C wavefront.
module mem_a_skew
  import mem_a_pkg::*;
#(
  parameter int BITS_AB  = 8,
  parameter int DIM      = 8,
  parameter int CNT_BITS = cnt_bits(DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     WrEn,
  input  logic [$clog2(DIM)-1:0]   Arow,
  input  logic [DIM*BITS_AB-1:0]   Ain,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic                     Avalid,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_BITS = $clog2(DIM);
  localparam logic [CNT_BITS-1:0] T_LAST = CNT_BITS'(stream_len(DIM) - 1);
  localparam logic [CNT_BITS-1:0] T_OOR  = CNT_BITS'(DIM);

  skew_state_t              state_q, state_d;
  logic [CNT_BITS-1:0]      t_q, t_d;
  logic [DIM*BITS_AB-1:0]   aout_q, aout_d;
  logic                     avalid_q, avalid_d;
  logic                     done_q, done_d;
  logic [DIM*BITS_AB-1:0]   col_s;

  // Per-row storage plus skew index: row r reads column t-r, or nothing when t<r.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    logic                 we_s;
    logic [CNT_BITS-1:0]  ridx_s;

    // Writes land only while idle; an Arow beyond the last row selects no row.
    assign we_s = (state_q == IDLE) && WrEn && (Arow == ROW_BITS'(r));

    // Column index for this row; t<r maps to an index that reads as 0.
    always_comb begin
      if (t_q >= CNT_BITS'(r)) begin
        ridx_s = t_q - CNT_BITS'(r);
      end else begin
        ridx_s = T_OOR;
      end
    end

    mem_a_row #(
      .BITS_AB  (BITS_AB),
      .DIM      (DIM),
      .IDX_BITS (CNT_BITS)
    ) u_row (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we_s),
      .wdata_i (Ain),
      .ridx_i  (ridx_s),
      .rdata_o (col_s[r*BITS_AB +: BITS_AB])
    );
  end

  // Stream FSM: load/arm in IDLE, one skewed column per enabled edge in STREAM.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    aout_d   = aout_q;
    avalid_d = avalid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        aout_d   = '0;
        avalid_d = 1'b0;
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (en) begin
          aout_d   = col_s;
          avalid_d = 1'b1;
          if (t_q == T_LAST) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + CNT_BITS'(1);
          end
        end else begin
          t_d = t_q;
        end
      end
      default: begin
        state_d  = IDLE;
        t_d      = '0;
        aout_d   = '0;
        avalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      aout_q   <= '0;
      avalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      aout_q   <= aout_d;
      avalid_q <= avalid_d;
      done_q   <= done_d;
    end
  end

  assign Aout   = aout_q;
  assign Avalid = avalid_q;
  assign done   = done_q;
  assign busy   = (state_q == STREAM);

endmodule

// File: tb/tb_mem_a_skew.sv
// Directed scoreboard bench for mem_a_skew with a 4x4 tile of bytes.
module tb_mem_a_skew;

  localparam int BITS_AB = 8;
  localparam int DIM     = 4;
  localparam int NCOL    = 2 * DIM - 1;

  logic                   clk = 1'b0;
  logic                   rst, en, WrEn, start;
  logic [1:0]             Arow;
  logic [DIM*BITS_AB-1:0] Ain;
  logic [DIM*BITS_AB-1:0] Aout;
  logic                   Avalid, busy, done;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model [DIM][DIM];
  logic [31:0] exp_q [$];
  logic [31:0] obs_cols [NCOL];
  int          nval;

  mem_a_skew #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
    .start(start), .Aout(Aout), .Avalid(Avalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Expected skewed column t from the bench's own copy of the tile.
  function automatic logic [31:0] model_col(input int t);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < DIM; r++) begin
      if ((t - r) >= 0 && (t - r) < DIM) v[r*8 +: 8] = model[r][t-r];
    end
    return v;
  endfunction

  task automatic wr_row(input int r, input logic [31:0] d);
    WrEn = 1'b1; Arow = 2'(r); Ain = d;
    for (int c = 0; c < DIM; c++) model[r][c] = d[c*8 +: 8];
    step();
    WrEn = 1'b0;
  endtask

  // Start a stream, optionally stall / poke WrEn+start mid-stream, check every column.
  task automatic run_stream(input int stall_after, input int stall_len,
                            input bit poke_mid, input bit wr_with_start,
                            input logic [31:0] wdata0, output int n_valid);
    int en_edges, stalls;
    bit en_now, finished;
    logic [31:0] prev, expc;
    en_edges = 0; stalls = 0; finished = 1'b0; prev = '0; n_valid = 0;
    if (wr_with_start) begin
      WrEn = 1'b1; Arow = 2'd0; Ain = wdata0;
      for (int c = 0; c < DIM; c++) model[0][c] = wdata0[c*8 +: 8];
    end
    for (int t = 0; t < NCOL; t++) exp_q.push_back(model_col(t));
    start = 1'b1; en = 1'b1;
    step();
    start = 1'b0; WrEn = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      en_now = !(en_edges == stall_after && stalls < stall_len);
      if (!en_now) stalls++;
      en = en_now;
      if (poke_mid && en_edges == 1) begin
        start = 1'b1;
      end else if (poke_mid && en_edges == 3) begin
        WrEn = 1'b1; Arow = 2'd1; Ain = 32'h55555555;
      end else begin
        start = 1'b0; WrEn = 1'b0;
      end
      step();
      if (en_now) begin
        en_edges++;
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'd1, 64'd0);
          expc = '0;
        end else begin
          expc = exp_q.pop_front();
        end
        chk("aout_col", 64'(Aout), 64'(expc));
        obs_cols[en_edges-1] = Aout;
        prev = expc;
        finished = (en_edges == NCOL);
        chk("done_flag", 64'(done), 64'(finished));
        chk("busy_flag", 64'(busy), 64'(!finished));
      end else begin
        chk("aout_hold", 64'(Aout), 64'(prev));
        chk("done_in_stall", 64'(done), 64'd0);
      end
      chk("avalid_hi", 64'(Avalid), 64'd1);
      n_valid++;
    end
    start = 1'b0; WrEn = 1'b0;
    if (!finished) chk("stream_timeout", 64'd1, 64'd0);
    step();
    chk("aout_after_done", 64'(Aout), 64'd0);
    chk("avalid_after_done", 64'(Avalid), 64'd0);
    chk("done_cleared", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; WrEn = 1'b0; start = 1'b0; Arow = '0; Ain = '0;
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) model[r][c] = 8'd0;
    step();
    chk("rst_aout", 64'(Aout), 64'd0);
    chk("rst_avalid", 64'(Avalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    // Base tile M[r][c] = 16r + c, continuous enable.
    for (int r = 0; r < DIM; r++)
      wr_row(r, pack4(8'(16*r), 8'(16*r+1), 8'(16*r+2), 8'(16*r+3)));
    run_stream(-1, 0, 1'b0, 1'b0, 32'd0, nval);
    chk("valid_cycles_plain", 64'(nval), 64'd7);
    chk("t1_literal", 64'(obs_cols[1]), 64'h00001001);
    chk("t3_literal", 64'(obs_cols[3]), 64'h30211203);
    chk("t6_literal", 64'(obs_cols[6]), 64'h33000000);

    // Three-cycle stall after t2.
    run_stream(3, 3, 1'b0, 1'b0, 32'd0, nval);
    chk("valid_cycles_stall", 64'(nval), 64'd10);

    // WrEn and start during the stream are ignored; then row 1 still original.
    run_stream(-1, 0, 1'b1, 1'b0, 32'd0, nval);
    run_stream(-1, 0, 1'b0, 1'b0, 32'd0, nval);
    chk("row1_after_poke", 64'(obs_cols[1]), 64'h00001001);

    // Signed extremes.
    wr_row(0, pack4(8'd0, 8'd1, 8'd2, 8'h7F));
    wr_row(3, pack4(8'h80, 8'd49, 8'd50, 8'd51));
    run_stream(-1, 0, 1'b0, 1'b0, 32'd0, nval);
    chk("signed_t3", 64'(obs_cols[3]), 64'h8021127F);

    // Reset in mid-stream clears everything, including the tile.
    start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_aout", 64'(Aout), 64'd0);
    chk("midrst_avalid", 64'(Avalid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) model[r][c] = 8'd0;
    run_stream(-1, 0, 1'b0, 1'b0, 32'd0, nval);

    // Write row 0 in the same cycle as start.
    run_stream(-1, 0, 1'b1, 1'b1, 32'h09090909, nval);
    chk("same_cycle_t0", 64'(obs_cols[0]), 64'h00000009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_a_skew.md
Name: mem_a_skew

Overview:
- Operand-A staging buffer that sits directly upstream of the tpumac systolic array.
- Holds a DIM x DIM tile of signed A operands, loaded one row per cycle.
- On command, streams the tile column by column with diagonal skew: row r is delayed r cycles, so each array row's Ain arrives aligned with the B/C wavefront.
- Output drives the Ain inputs of the left-edge MAC column; the en stall semantics match the array's register enable.

Parameters:
- BITS_AB, 8, width of one signed A element.
- DIM, 8, tile dimension (rows = columns = array height); DIM >= 2.
- CNT_BITS, $clog2(2*DIM), width of the stream counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  stream advance enable; low stalls the stream.
- WrEn  input  1  row write strobe.
- Arow  input  $clog2(DIM)  row index for the write.
- Ain  input  DIM*BITS_AB  row data; element c is bits [c*BITS_AB +: BITS_AB].
- start  input  1  begin streaming the stored tile.
- Aout  output  DIM*BITS_AB  skewed column; element r feeds array row r.
- Avalid  output  1  Aout holds stream-phase data.
- busy  output  1  high while in STREAM.
- done  output  1  one-cycle pulse after the final stream column.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter t=0, every matrix element M[r][c]=0, Aout=0, Avalid=0, busy=0, done=0. Reset overrides all other inputs, including mid-stream.
- States: IDLE, STREAM. busy = (state==STREAM), combinational from state.
- IDLE:
  - WrEn=1 -> M[Arow][c] <= Ain element c for all c.
  - start=1 -> state<=STREAM, t<=0.
  - Aout<=0, Avalid<=0.
  - en is ignored.
- STREAM with en=1, each edge:
  - Aout[r] <= M[r][t-r] when 0 <= t-r < DIM, else 0.
  - Avalid<=1; t<=t+1.
  - When t==2*DIM-2: state<=IDLE, t<=0, done<=1 on the same edge as the last column.
- STREAM with en=0: t, Aout and Avalid hold; no progress.
- Latency: start sampled at edge 0; first column (Aout[0]=M[0][0], others 0) appears after edge 1. Stream length is exactly 2*DIM-1 enabled edges.
- done: high exactly one cycle, during the cycle after the last column is registered; cleared on the next edge regardless of en.
- Avalid drops to 0 on the edge after the last column (IDLE zeroes Aout), so Avalid/Aout return to 0 the cycle done is high... precisely: the last column is visible with Avalid=1 while done=1; both Aout and Avalid clear on the following edge.
- WrEn during STREAM: ignored; the matrix is frozen while streaming.
- start during STREAM: ignored, no restart.
- start and WrEn in the same IDLE cycle: both accepted. The written row is visible to the stream, since the first read occurs on a later edge.
- Arithmetic: pure data movement, no sign extension or truncation. Out-of-skew positions are 0, so they contribute nothing to downstream MAC sums.
- Arow >= DIM (non-power-of-two DIM): the write is dropped.

Decomposition:
- Package mem_a_pkg:
  - typedef enum logic {IDLE, STREAM} skew_state_t;
  - localparam functions for stream length (2*DIM-1) and counter width.
- Sub-module mem_a_row (one per row, generate loop):
  - Holds DIM elements; write-enable port; combinational read by column index.
  - Returns 0 for out-of-range index.
- Top level holds the FSM, counter t, skew index computation, and the output register.

Test Plan:
- DIM=4; write rows M[r][c]=16*r+c; start; en=1 constantly -> Aout rows:
  - t0: (0,0,0,0)
  - t1: (1,16,0,0)
  - t2: (2,17,32,0)
  - t3: (3,18,33,48)
  - t4: (0,19,34,49)
  - t5: (0,0,35,50)
  - t6: (0,0,0,51)
  - done pulses with t6 visible; Avalid high for exactly 7 cycles.
- Same tile with en low for 3 cycles after t2 -> Aout holds (2,17,32,0) for those 3 cycles; remaining sequence unchanged; total 10 cycles from the first column to done.
- Signed data: M[3][0]=-128 (0x80), M[0][3]=127 -> 0x80 appears on Aout row 3 at t3; 0x7F appears on row 0 at t3; no sign corruption.
- WrEn with Arow=1, Ain=all 0x55 asserted during STREAM at t2 -> streamed data unchanged; after done, a second start streams the original row 1.
- rst asserted at t3 -> next cycle Aout=0, Avalid=0, busy=0, done=0; a following start streams all zeros (matrix cleared).
- start and WrEn(Arow=0, Ain=9,9,9,9) in the same cycle -> Aout[0] at t0 = 9; start asserted during STREAM has no effect.
